// File: rtl/priority_way_encoder_pkg.sv
// Shared constants and types for the priority way encoder.
// Holds the priority-mode codes, the multi-hit counter width and the output FSM state type.
package priority_way_encoder_pkg;

   localparam int PRI_LOW     = 0;
   localparam int PRI_HIGH    = 1;
   localparam int PRI_RR      = 2;
   localparam int MULTI_CNT_W = 16;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_e;

endpackage

// File: rtl/priority_way_encoder_find_first.sv
// Combinational find-first-set: returns the lowest set index of vec_i and whether any bit was set.
// An all-zero vector yields index 0 with found_o low.
module way_find_first #(
   parameter  int WAYS  = 8,
   localparam int IDX_W = $clog2(WAYS)
) (
   input  logic [WAYS-1:0]  vec_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             found_o
);

   // Scanning downward lets the lowest set bit be the last writer.
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            idx_o   = IDX_W'(i);
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/priority_way_encoder.sv
// Registered way-selection encoder with a one-entry valid/ready output stage.
// Supports lowest-first, highest-first and round-robin priority over a way hit vector.
module priority_way_encoder
   import priority_way_encoder_pkg::*;
#(
   parameter  int WAYS  = 8,
   parameter  int MODE  = PRI_LOW,
   localparam int IDX_W = $clog2(WAYS)
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WAYS-1:0]        in_vec,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [IDX_W-1:0]       out_idx,
   output logic                   out_none,
   output logic                   out_multi,
   output logic [MULTI_CNT_W-1:0] multi_count
);

   // Handshake: a vector moves on a rising edge when in_valid && in_ready; a held result
   // leaves on a rising edge when out_valid && out_ready. in_ready depends only on state
   // and out_ready, so a new vector can replace a result in the cycle it is consumed.

   out_state_e             state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic                   none_q, none_d;
   logic                   multi_q, multi_d;
   logic [MULTI_CNT_W-1:0] mcount_q, mcount_d;

   logic                   accept;
   logic                   vec_multi;
   logic                   found;
   logic [WAYS-1:0]        search_vec;
   logic [IDX_W-1:0]       ff_idx;
   logic [IDX_W-1:0]       sel_idx;
   logic [IDX_W:0]         idx_sum;

   assign in_ready  = (state_q == ST_EMPTY) || out_ready;
   assign accept    = in_valid && in_ready;
   assign vec_multi = |(in_vec & (in_vec - WAYS'(1)));

   // Highest-first reverses the vector; round-robin rotates it so bit 0 is way ptr.
   always_comb begin
      search_vec = in_vec;
      if (MODE == PRI_HIGH) begin
         for (int i = 0; i < WAYS; i++) begin
            search_vec[i] = in_vec[WAYS-1-i];
         end
      end else if (MODE == PRI_RR) begin
         for (int i = 0; i < WAYS; i++) begin
            if (i + int'(ptr_q) >= WAYS) begin
               search_vec[i] = in_vec[i + int'(ptr_q) - WAYS];
            end else begin
               search_vec[i] = in_vec[i + int'(ptr_q)];
            end
         end
      end
   end

   way_find_first #(
      .WAYS (WAYS)
   ) u_find_first (
      .vec_i   (search_vec),
      .idx_o   (ff_idx),
      .found_o (found)
   );

   // Map the index in the searched vector back to the way number.
   always_comb begin
      idx_sum = {1'b0, ff_idx} + {1'b0, ptr_q};
      sel_idx = ff_idx;
      if (MODE == PRI_HIGH) begin
         sel_idx = IDX_W'(WAYS - 1) - ff_idx;
      end else if (MODE == PRI_RR) begin
         if (idx_sum >= (IDX_W+1)'(WAYS)) begin
            sel_idx = IDX_W'(idx_sum - (IDX_W+1)'(WAYS));
         end else begin
            sel_idx = idx_sum[IDX_W-1:0];
         end
      end
      if (!found) begin
         sel_idx = '0;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      none_d   = none_q;
      multi_d  = multi_q;
      ptr_d    = ptr_q;
      mcount_d = mcount_q;

      case (state_q)
         ST_EMPTY: if (accept) state_d = ST_FULL;
         ST_FULL:  if (out_ready && !accept) state_d = ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase

      if (accept) begin
         idx_d   = sel_idx;
         none_d  = !found;
         multi_d = vec_multi;
         if (vec_multi && (mcount_q != {MULTI_CNT_W{1'b1}})) begin
            mcount_d = mcount_q + MULTI_CNT_W'(1);
         end
      end

      // Pointer moves one past the granted way; it stays put for an empty vector.
      if (MODE == PRI_RR) begin
         if (accept && found) begin
            ptr_d = (sel_idx == IDX_W'(WAYS - 1)) ? '0 : sel_idx + IDX_W'(1);
         end
      end else begin
         ptr_d = '0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_EMPTY;
         idx_q    <= '0;
         none_q   <= 1'b0;
         multi_q  <= 1'b0;
         ptr_q    <= '0;
         mcount_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         none_q   <= none_d;
         multi_q  <= multi_d;
         ptr_q    <= ptr_d;
         mcount_q <= mcount_d;
      end
   end

   assign out_valid   = (state_q == ST_FULL);
   assign out_idx     = idx_q;
   assign out_none    = none_q;
   assign out_multi   = multi_q;
   assign multi_count = mcount_q;

endmodule

// File: tb/tb_priority_way_encoder.sv
// Bench for priority_way_encoder: four instances (WAYS=8 modes 0/1/2, WAYS=6 mode 2)
// driven one at a time, with results checked against a scoreboard queue.
module tb_priority_way_encoder;

   localparam int N = 4;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        in_valid_a  [N];
   logic [7:0]  in_vec_a    [N];
   logic        in_ready_a  [N];
   logic        out_valid_a [N];
   logic        out_ready_a [N];
   logic [2:0]  out_idx_a   [N];
   logic        out_none_a  [N];
   logic        out_multi_a [N];
   logic [15:0] mc_a        [N];

   // Entry layout: {multi_count[15:0], none, multi, idx[2:0]}
   logic [20:0] exp_q[$];
   logic [20:0] mon_e;

   int checks = 0;
   int errors = 0;
   int cur = 0;
   bit rand_rdy = 1'b0;
   int ptr_m [N];
   int mc_m  [N];

   always #5 clock = ~clock;

   priority_way_encoder #(.WAYS(8), .MODE(0)) dut0 (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
      .in_vec(in_vec_a[0]), .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
      .out_idx(out_idx_a[0]), .out_none(out_none_a[0]), .out_multi(out_multi_a[0]),
      .multi_count(mc_a[0]));

   priority_way_encoder #(.WAYS(8), .MODE(1)) dut1 (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
      .in_vec(in_vec_a[1]), .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
      .out_idx(out_idx_a[1]), .out_none(out_none_a[1]), .out_multi(out_multi_a[1]),
      .multi_count(mc_a[1]));

   priority_way_encoder #(.WAYS(8), .MODE(2)) dut2 (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
      .in_vec(in_vec_a[2]), .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]),
      .out_idx(out_idx_a[2]), .out_none(out_none_a[2]), .out_multi(out_multi_a[2]),
      .multi_count(mc_a[2]));

   priority_way_encoder #(.WAYS(6), .MODE(2)) dut3 (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid_a[3]), .in_ready(in_ready_a[3]),
      .in_vec(in_vec_a[3][5:0]), .out_valid(out_valid_a[3]), .out_ready(out_ready_a[3]),
      .out_idx(out_idx_a[3]), .out_none(out_none_a[3]), .out_multi(out_multi_a[3]),
      .multi_count(mc_a[3]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s dut=%0d observed=%0h expected=%0h t=%0t", tag, cur, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] get_ptr(input int sel);
      case (sel)
         0:       return 32'(dut0.ptr_q);
         1:       return 32'(dut1.ptr_q);
         2:       return 32'(dut2.ptr_q);
         default: return 32'(dut3.ptr_q);
      endcase
   endfunction

   // Called at a falling edge; returns at the falling edge after the vector is accepted.
   task automatic drive(input int sel, input logic [7:0] vec);
      int  w, m, idx, cnt, waited;
      bit  found;
      w = (sel == 3) ? 6 : 8;
      m = (sel == 3) ? 2 : sel;
      in_valid_a[sel] = 1'b1;
      in_vec_a[sel]   = vec;
      waited = 0;
      #2;
      while (!in_ready_a[sel] && waited < 50) begin
         @(negedge clock);
         #2;
         waited++;
      end
      if (!in_ready_a[sel]) begin
         check("accept_timeout", 32'(in_ready_a[sel]), 1);
         @(negedge clock);
         return;
      end
      cnt = 0;
      for (int i = 0; i < w; i++) if (vec[i]) cnt++;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < w; k++) begin
         int i;
         case (m)
            0:       i = k;
            1:       i = w - 1 - k;
            default: i = (ptr_m[sel] + k) % w;
         endcase
         if (!found && vec[i]) begin
            found = 1'b1;
            idx   = i;
         end
      end
      if (m == 2 && found) ptr_m[sel] = (idx + 1) % w;
      if (cnt >= 2 && mc_m[sel] < 65535) mc_m[sel]++;
      exp_q.push_back({16'(mc_m[sel]), (cnt == 0), (cnt >= 2), 3'(idx)});
      @(negedge clock);
      check("ptr", get_ptr(sel), 32'(ptr_m[sel]));
   endtask

   task automatic idle(input int sel);
      in_valid_a[sel] = 1'b0;
   endtask

   always @(negedge clock) begin
      if (rand_rdy) out_ready_a[cur] = 1'($urandom_range(0, 1));
   end

   // Output monitor: compares each result in the cycle the consumer takes it.
   always @(negedge clock) begin
      #1;
      if (reset_n && out_valid_a[cur] && out_ready_a[cur]) begin
         check("sb_nonempty", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("out_idx",     32'(out_idx_a[cur]),   32'(mon_e[2:0]));
            check("out_multi",   32'(out_multi_a[cur]), 32'(mon_e[3]));
            check("out_none",    32'(out_none_a[cur]),  32'(mon_e[4]));
            check("multi_count", 32'(mc_a[cur]),        32'(mon_e[20:5]));
         end
      end
   end

   initial begin
      #950000;
      $display("FAIL watchdog observed=timeout expected=finish t=%0t", $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] vec;
      reset_n = 1'b0;
      for (int k = 0; k < N; k++) begin
         in_valid_a[k]  = 1'b0;
         in_vec_a[k]    = '0;
         out_ready_a[k] = 1'b1;
         ptr_m[k] = 0;
         mc_m[k]  = 0;
      end
      repeat (3) @(negedge clock);
      for (int k = 0; k < N; k++) begin
         cur = k;
         check("rst_out_valid",   32'(out_valid_a[k]), 0);
         check("rst_out_idx",     32'(out_idx_a[k]),   0);
         check("rst_out_none",    32'(out_none_a[k]),  0);
         check("rst_out_multi",   32'(out_multi_a[k]), 0);
         check("rst_multi_count", 32'(mc_a[k]),        0);
         check("rst_ptr",         get_ptr(k),          0);
      end
      reset_n = 1'b1;
      @(negedge clock);
      #2;
      for (int k = 0; k < N; k++) begin
         cur = k;
         check("post_rst_in_ready", 32'(in_ready_a[k]), 1);
      end
      @(negedge clock);

      // Lowest-first
      cur = 0;
      drive(0, 8'b0010_1000);
      #3;
      check("m0_out_valid", 32'(out_valid_a[0]), 1);
      idle(0);
      @(negedge clock);
      drive(0, 8'h00);
      drive(0, 8'b1001_0000);
      idle(0);
      repeat (2) @(negedge clock);

      // Highest-first
      cur = 1;
      drive(1, 8'b0010_1000);
      drive(1, 8'h00);
      drive(1, 8'h81);
      idle(1);
      repeat (2) @(negedge clock);

      // Round-robin alternation
      cur = 2;
      repeat (4) drive(2, 8'b1000_0001);
      idle(2);
      repeat (2) @(negedge clock);

      // Back-pressure: result must hold while the consumer stalls
      cur = 0;
      out_ready_a[0] = 1'b0;
      drive(0, 8'b0000_0110);
      in_vec_a[0] = 8'h40;
      for (int c = 0; c < 5; c++) begin
         #2;
         check("hold_in_ready",  32'(in_ready_a[0]),  0);
         check("hold_out_valid", 32'(out_valid_a[0]), 1);
         check("hold_out_idx",   32'(out_idx_a[0]),   1);
         @(negedge clock);
      end
      out_ready_a[0] = 1'b1;
      drive(0, 8'h40);
      #3;
      check("reload_out_valid", 32'(out_valid_a[0]), 1);
      check("reload_out_idx",   32'(out_idx_a[0]),   6);
      idle(0);
      repeat (2) @(negedge clock);

      // Random traffic with random consumer stalls
      for (int s = 0; s < N; s++) begin
         cur = s;
         rand_rdy = 1'b1;
         for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 5) == 0) vec = 8'h00;
            else vec = 8'($urandom_range(0, 255));
            if (s == 3) vec[7:6] = 2'b00;
            drive(s, vec);
            if ($urandom_range(0, 3) == 0) begin
               idle(s);
               @(negedge clock);
            end
         end
         idle(s);
         rand_rdy = 1'b0;
         @(negedge clock);
         out_ready_a[s] = 1'b1;
         repeat (3) @(negedge clock);
      end

      // Counter saturation
      cur = 0;
      for (int t = 0; t < 65540; t++) drive(0, 8'hFF);
      idle(0);
      repeat (3) @(negedge clock);
      check("sat_multi_count", 32'(mc_a[0]), 32'h0000_FFFF);

      // Non-power-of-two round-robin, then asynchronous reset while holding a result
      cur = 3;
      drive(3, 8'b0000_0011);
      drive(3, 8'b0010_0000);
      out_ready_a[3] = 1'b0;
      idle(3);
      #2;
      check("w6_out_valid", 32'(out_valid_a[3]), 1);
      check("w6_out_idx",   32'(out_idx_a[3]),   5);
      reset_n = 1'b0;
      #1;
      check("async_out_valid",   32'(out_valid_a[3]), 0);
      check("async_out_idx",     32'(out_idx_a[3]),   0);
      check("async_multi_count", 32'(mc_a[3]),        0);
      check("async_sat_cleared", 32'(mc_a[0]),        0);
      check("async_ptr",         get_ptr(3),          0);
      exp_q.delete();
      for (int k = 0; k < N; k++) begin
         ptr_m[k] = 0;
         mc_m[k]  = 0;
      end
      @(negedge clock);
      reset_n = 1'b1;
      out_ready_a[3] = 1'b1;
      @(negedge clock);
      #2;
      check("rerst_in_ready",  32'(in_ready_a[3]),  1);
      check("rerst_out_valid", 32'(out_valid_a[3]), 0);
      @(negedge clock);
      drive(3, 8'b0000_0110);
      idle(3);
      repeat (3) @(negedge clock);

      check("sb_drain", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
